// File: rtl/updown_counter_pkg.sv
// Shared pad-bit positions and helper functions for the modulo-N up/down counter.
package updown_counter_pkg;

  localparam int RST_BIT  = 0;
  localparam int EN_BIT   = 1;
  localparam int DIR_BIT  = 2;
  localparam int LOAD_BIT = 3;
  localparam int LD_LSB   = 4;

  // Count width: one pad bit is reserved for the terminal-count flag.
  function automatic int cw_of(input int width);
    return width - 1;
  endfunction

  function automatic logic [31:0] clamp_ld(input logic [31:0] val, input int modulus);
    logic [31:0] max_val;
    max_val = 32'(modulus - 1);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/updown_counter_prescaler.sv
// Enable prescaler: pulses tick once every PRESCALE enabled, non-clear cycles.
// Latency: tick is combinational from en/clr and the registered phase counter ps.
// Backpressure: none; ps freezes while en is low and restarts from 0 on en & clr.
module updown_counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps;

  assign tick = en & ~clr & (ps == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      ps <= '0;
    end else if (en & clr) begin
      ps <= '0;
    end else if (tick) begin
      ps <= '0;
    end else if (en) begin
      ps <= ps + PW'(1);
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Modulo-N up/down counter with load, prescaler and terminal-count flag on the pad bus.
// Latency: io_in to io_out is one cycle, all outputs registered. Saturating build: COUNTER_SATURATE_EN.
// Backpressure: none; en=0 holds count and phase, clearing tc.
module updown_counter_mod
  import updown_counter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MODULUS  = 2 ** (WIDTH - 1),
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oeb
);

  localparam int CW = cw_of(WIDTH);
  localparam logic [CW-1:0] MAX = CW'(MODULUS - 1);

  logic                      rst;
  logic                      en;
  logic                      dir;
  logic                      load;
  logic [WIDTH-LD_LSB-1:0]   ld_raw;
  logic [CW-1:0]             ld_val;
  logic                      tick;
  logic [CW-1:0]             count;
  logic                      tc;
  logic [CW-1:0]             count_nxt;
  logic                      boundary;

  assign rst    = io_in[RST_BIT];
  assign en     = io_in[EN_BIT];
  assign dir    = io_in[DIR_BIT];
  assign load   = io_in[LOAD_BIT];
  assign ld_raw = io_in[WIDTH-1:LD_LSB];
  assign ld_val = CW'(clamp_ld(32'(ld_raw), MODULUS));

  updown_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  // Next count on a tick; boundary flags the step that wraps (or is blocked).
  always_comb begin
    count_nxt = count;
    boundary  = 1'b0;
    if (dir) begin
      if (count == MAX) begin
        boundary = 1'b1;
`ifdef COUNTER_SATURATE_EN
        count_nxt = MAX;
`else
        count_nxt = '0;
`endif
      end else begin
        count_nxt = count + CW'(1);
      end
    end else begin
      if (count == '0) begin
        boundary = 1'b1;
`ifdef COUNTER_SATURATE_EN
        count_nxt = '0;
`else
        count_nxt = MAX;
`endif
      end else begin
        count_nxt = count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (en & load) begin
      count <= ld_val;
      tc    <= 1'b0;
    end else if (tick) begin
      count <= count_nxt;
      tc    <= boundary;
    end else begin
      tc    <= 1'b0;
    end
  end

  assign io_out = {tc, count};
  assign io_oeb = '1;

endmodule
